// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I subset core.
// Optional retired-instruction counter: define RV_CTRL_PERF_EN.
module rv_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       alu_src_imm,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state_o
`ifdef RV_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
    $error("rv_multicycle_ctrl: bad parameter");
  end

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC   = 4'd3,
    ADDR   = 4'd4,
    MEM    = 4'd5,
    WB     = 4'd6,
    BRANCH = 4'd7,
    TRAP   = 4'd8
  } state_t;

  state_t         state, state_d;
  logic [1:0]     cause_d;
  logic [WCW-1:0] wcnt, wcnt_d;
  logic           tmo;
  logic           retire;
  logic           is_alu, is_mem, is_br;

  assign is_alu = (opcode == OP_R) || (opcode == OP_I);
  assign is_mem = (opcode == OP_LD) || (opcode == OP_ST);
  assign is_br  = (opcode == OP_BR);
  // The MEM_TIMEOUT-th idle cycle traps; ready on that cycle still wins.
  assign tmo    = (wcnt == WCW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trap_cause <= 2'b00;
      wcnt       <= '0;
    end else begin
      state      <= state_d;
      trap_cause <= cause_d;
      wcnt       <= wcnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    cause_d      = trap_cause;
    wcnt_d       = '0;
    retire       = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src_imm  = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 1'b0;
    trap         = 1'b0;
    unique case (state)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        if (mem_ready) begin
          state_d = DECODE;
        end else if (tmo) begin
          state_d = TRAP;
          cause_d = 2'b10;
        end else begin
          wcnt_d = wcnt + WCW'(1);
        end
      end
      DECODE: begin
        unique case (1'b1)
          is_alu:  state_d = EXEC;
          is_mem:  state_d = ADDR;
          is_br:   state_d = BRANCH;
          default: begin
            state_d = TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      EXEC: begin
        alu_src_imm = (opcode == OP_I);
        state_d     = WB;
      end
      ADDR: begin
        alu_src_imm = 1'b1;
        state_d     = MEM;
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_ST);
        if (mem_ready) begin
          if (opcode == OP_ST) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (tmo) begin
          state_d = TRAP;
          cause_d = 2'b10;
        end else begin
          wcnt_d = wcnt + WCW'(1);
        end
      end
      WB: begin
        reg_we      = 1'b1;
        wb_sel      = (opcode == OP_LD);
        alu_src_imm = (opcode == OP_I);
        pc_we       = 1'b1;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        pc_we   = 1'b1;
        pc_src  = branch_taken;
        retire  = 1'b1;
        state_d = FETCH;
      end
      TRAP: trap = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  assign state_o = (state == TRAP) ? 3'b111 : state[2:0];

`ifdef RV_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule
